// File: rtl/serial_alu.sv
// Bit-serial ALU sequencer: one 1-bit ALU slice plus a bit counter, producing one result bit per clock.
// Build option: define SERIAL_ALU_OVF_EN to drive overflow and use an overflow-corrected set-less-than.
module serial_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             a_invert,
    input  logic             b_invert,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             co,
    output logic             zero,
    output logic             overflow
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SLT = 2'b11;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             accept;
    logic             finish;
    logic             busy_nxt;
    logic             done_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] shift;
    logic             a_inv_q;
    logic             b_inv_q;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             last_bit;

    logic             ai;
    logic             bi;
    logic             sum;
    logic             cout;
    logic             slice_out;
    logic             ovf_msb;
    logic             set_bit;
    logic [WIDTH-1:0] final_shift;
    logic [WIDTH-1:0] result_nxt;
    logic             zero_nxt;
    logic             overflow_nxt;

    assign last_bit = (cnt == LAST_BIT);

    // One-bit ALU slice on the current LSB of the operand shifters.
    always_comb begin
        ai        = a_sh[0] ^ a_inv_q;
        bi        = b_sh[0] ^ b_inv_q;
        sum       = ai ^ bi ^ carry;
        cout      = (ai & bi) | (ai & carry) | (bi & carry);
        slice_out = 1'b0;
        case (op_q)
            OP_AND:  slice_out = ai & bi;
            OP_OR:   slice_out = ai | bi;
            OP_ADD:  slice_out = sum;
            OP_SLT:  slice_out = 1'b0;
            default: slice_out = 1'b0;
        endcase
    end

    // At the MSB, carry holds the carry into the slice, so overflow is carry-in xor carry-out.
`ifdef SERIAL_ALU_OVF_EN
    always_comb begin
        ovf_msb      = carry ^ cout;
        set_bit      = sum ^ ovf_msb;
        overflow_nxt = op_q[1] & ovf_msb;
    end
`else
    always_comb begin
        ovf_msb      = 1'b0;
        set_bit      = sum;
        overflow_nxt = ovf_msb;
    end
`endif

    // Final result as it will look once the MSB slice output is shifted in.
    always_comb begin
        final_shift = {slice_out, shift[WIDTH-1:1]};
        if (op_q == OP_SLT) begin
            result_nxt = {{(WIDTH-1){1'b0}}, set_bit};
        end else begin
            result_nxt = final_shift;
        end
        zero_nxt = (result_nxt == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; start is only honoured from IDLE or DONE.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    accept    = 1'b1;
                end
            end
            S_RUN: begin
                if (last_bit) begin
                    state_nxt = S_DONE;
                    finish    = 1'b1;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    accept    = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        busy_nxt = (state_nxt == S_RUN);
        done_nxt = (state_nxt == S_DONE);
    end

    // Operand shifters, bit counter, carry chain and partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            shift   <= '0;
            a_inv_q <= 1'b0;
            b_inv_q <= 1'b0;
            op_q    <= OP_AND;
            cnt     <= '0;
            carry   <= 1'b0;
        end else if (accept) begin
            a_sh    <= a;
            b_sh    <= b;
            shift   <= '0;
            a_inv_q <= a_invert;
            b_inv_q <= b_invert;
            op_q    <= op;
            cnt     <= '0;
            carry   <= b_invert;
        end else if (state == S_RUN) begin
            a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
            shift <= final_shift;
            carry <= cout;
            if (last_bit) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Visible outputs; result flags move only on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            co       <= 1'b0;
            zero     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            busy <= busy_nxt;
            done <= done_nxt;
            if (finish) begin
                result   <= result_nxt;
                co       <= cout;
                zero     <= zero_nxt;
                overflow <= overflow_nxt;
            end
        end
    end

endmodule

// File: tb/tb_serial_alu.sv
// Scoreboard bench for serial_alu at WIDTH=8: arithmetic reference model, queued expectations, monitor on done.
module tb_serial_alu;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         a_invert = 1'b0;
    logic         b_invert = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         co;
    logic         zero;
    logic         overflow;

    typedef struct {
        logic [W-1:0] result;
        logic         co;
        logic         zero;
        logic         ovf;
        int           cyc;
    } exp_t;

    exp_t q[$];
    exp_t held;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   busy_len = 0;
    logic prev_done = 1'b0;

    serial_alu #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_invert (a_invert),
        .b_invert (b_invert),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .co       (co),
        .zero     (zero),
        .overflow (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain two's-complement arithmetic on the (optionally inverted) operands.
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                   input logic tai, input logic tbi, input logic [1:0] top);
        exp_t         e;
        logic [W-1:0] aa;
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic         sov;
        logic         less;
        aa   = tai ? ~ta : ta;
        bb   = tbi ? ~tb : tb;
        full = {1'b0, aa} + {1'b0, bb} + (W+1)'(tbi);
        sov  = (aa[W-1] == bb[W-1]) && (full[W-1] != aa[W-1]);
`ifdef SERIAL_ALU_OVF_EN
        less = full[W-1] ^ sov;
`else
        less = full[W-1];
`endif
        case (top)
            2'b00:   e.result = aa & bb;
            2'b01:   e.result = aa | bb;
            2'b10:   e.result = full[W-1:0];
            default: e.result = {{(W-1){1'b0}}, less};
        endcase
        e.co   = full[W];
        e.zero = (e.result == '0);
`ifdef SERIAL_ALU_OVF_EN
        e.ovf  = top[1] & sov;
`else
        e.ovf  = 1'b0;
`endif
        e.cyc  = 0;
        return e;
    endfunction

    // Called at #1 after a rising edge; returns at #1 after the edge that accepted start.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tai, input logic tbi, input logic [1:0] top);
        exp_t e;
        int   g = 0;
        while (busy && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        if (busy) check("issue_wait_timeout", 32'(busy), 32'd0);
        a = ta; b = tb; a_invert = tai; b_invert = tbi; op = top;
        start = 1'b1;
        e = model(ta, tb, tai, tbi, top);
        e.cyc = cyc + 1 + W;
        q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int g = 0;
        while (!done && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        if (!done) check("wait_done_timeout", 32'(done), 32'd1);
    endtask

    // Monitor: pops expectations on done, checks busy width and output stability during RUN.
    always @(negedge clk) begin
        if (rst) begin
            busy_len    = 0;
            prev_done   = 1'b0;
            held.result = '0;
            held.co     = 1'b0;
            held.zero   = 1'b0;
            held.ovf    = 1'b0;
        end else begin
            if (busy) begin
                busy_len++;
                check("hold_result", 32'(result), 32'(held.result));
                check("hold_flags", {29'd0, co, zero, overflow}, {29'd0, held.co, held.zero, held.ovf});
            end else if (busy_len != 0) begin
                check("busy_cycles", 32'(busy_len), 32'(W));
                busy_len = 0;
            end
            if (done) begin
                check("done_single_cycle", 32'(prev_done), 32'd0);
                if (q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    held = q.pop_front();
                    check("result", 32'(result), 32'(held.result));
                    check("co", 32'(co), 32'(held.co));
                    check("zero", 32'(zero), 32'(held.zero));
                    check("overflow", 32'(overflow), 32'(held.ovf));
                    check("latency_cycle", 32'(cyc), 32'(held.cyc));
                end
            end
            prev_done = done;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_flags", {29'd0, co, zero, overflow}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed scenarios at WIDTH=8.
        issue(8'h7F, 8'h01, 1'b0, 1'b0, 2'b10);
        wait_done();
        @(posedge clk); #1;
        issue(8'h05, 8'h05, 1'b0, 1'b1, 2'b10);
        wait_done();
        @(posedge clk); #1;
        issue(8'h80, 8'h01, 1'b0, 1'b1, 2'b11);
        wait_done();
        @(posedge clk); #1;

        // NOR followed by back-to-back OR issued while done is high.
        issue(8'hF0, 8'h0C, 1'b1, 1'b1, 2'b00);
        wait_done();
        issue(8'h0F, 8'h30, 1'b0, 1'b0, 2'b01);
        check("b2b_no_idle_busy", 32'(busy), 32'd1);
        wait_done();
        @(posedge clk); #1;

        // Reset on the third RUN cycle, with a coincident start that must be dropped.
        issue(8'h12, 8'h34, 1'b0, 1'b0, 2'b10);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        start = 1'b1;
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_flags", {29'd0, co, zero, overflow}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("abort_stays_idle", {30'd0, busy, done}, 32'd0);
        end
        @(posedge clk); #1;

        // Start with new operands on the fourth RUN cycle must be ignored.
        issue(8'h3C, 8'h5A, 1'b0, 1'b0, 2'b10);
        repeat (3) begin
            @(posedge clk); #1;
        end
        a = 8'hFF; b = 8'hFF; a_invert = 1'b1; b_invert = 1'b1; op = 2'b00;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        @(posedge clk); #1;

        // Randomized operations, mixing idle gaps and back-to-back starts.
        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 3) == 0) ra = 8'h80;
            if ($urandom_range(0, 3) == 0) rb = ra;
            issue(ra, rb, 1'($urandom), 1'($urandom), 2'($urandom));
            wait_done();
            if ($urandom_range(0, 2) != 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk); #1;
                end
            end
        end

        begin
            int g = 0;
            while (q.size() != 0 && g < 200) begin
                @(posedge clk); #1;
                g++;
            end
        end
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
